// File: rtl/sq_issue_scheduler_if.sv
// rtl/sq_issue_scheduler_if.sv - load/store queue head and subunit issue port bundle
interface sq_issue_scheduler_if;
   logic lq_valid;
   logic lq_store_conflict;
   logic lq_pop;
   logic sq_valid;
   logic sq_empty;
   logic sq_pop;
   logic mem_ready;
   logic issue_valid;
   logic issue_is_store;
   logic fence_req;
   logic fence_ack;

   modport master (
      output lq_valid, lq_store_conflict, sq_valid, sq_empty, mem_ready, fence_req,
      input  lq_pop, sq_pop, issue_valid, issue_is_store, fence_ack
   );

   modport slave (
      input  lq_valid, lq_store_conflict, sq_valid, sq_empty, mem_ready, fence_req,
      output lq_pop, sq_pop, issue_valid, issue_is_store, fence_ack
   );
endinterface

// File: rtl/sq_issue_scheduler.sv
// rtl/sq_issue_scheduler.sv - load/store head arbiter for the subunit port with fence drain
// SQ_SCHED_STARVE_EN enables the store starvation counter; without it loads always win in ARB.
module sq_issue_scheduler #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   sq_issue_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2
   } state_t;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("sq_issue_scheduler: STARVE_LIMIT out of range 1..255");
   end

   state_t state_q, state_d;
   logic   fence_ack_q, fence_ack_d;
   logic   load_ok, store_ok, force_store;
   logic   sel_load, sel_store;

   assign load_ok  = bus.lq_valid & ~bus.lq_store_conflict & (state_q == ARB);
   assign store_ok = bus.sq_valid;

`ifdef SQ_SCHED_STARVE_EN
   localparam int             CW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT_W = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;

   assign force_store = (starve_q == LIMIT_W);

   // Counter only tracks loads that overtook a waiting store; it saturates at the limit.
   always_comb begin
      starve_d = starve_q;
      if (bus.sq_pop || !bus.sq_valid) begin
         starve_d = '0;
      end else if (bus.lq_pop && (starve_q != LIMIT_W)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_store = 1'b0;
`endif

   always_comb begin
      sel_load  = 1'b0;
      sel_store = 1'b0;
      case (state_q)
         ARB: begin
            if (force_store && store_ok) begin
               sel_store = 1'b1;
            end else if (load_ok) begin
               sel_load = 1'b1;
            end else if (store_ok) begin
               sel_store = 1'b1;
            end
         end
         DRAIN: sel_store = store_ok;
         default: begin
            sel_load  = 1'b0;
            sel_store = 1'b0;
         end
      endcase
   end

   // Grants are gated by rst so nothing reaches the port while the block is held in reset.
   assign bus.issue_valid    = ~rst & (sel_load | sel_store);
   assign bus.issue_is_store = ~rst & sel_store;
   assign bus.lq_pop         = ~rst & sel_load  & bus.mem_ready;
   assign bus.sq_pop         = ~rst & sel_store & bus.mem_ready;
   assign bus.fence_ack      = fence_ack_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (bus.fence_req) state_d = DRAIN;
         DRAIN:   if (bus.sq_empty)  state_d = ACK;
         ACK:     state_d = ARB;
         default: state_d = ARB;
      endcase
      fence_ack_d = (state_d == ACK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB;
         fence_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fence_ack_q <= fence_ack_d;
      end
   end

endmodule

// File: tb/tb_sq_issue_scheduler.sv
// tb/tb_sq_issue_scheduler.sv - scoreboard bench for sq_issue_scheduler
module tb_sq_issue_scheduler;

   // Observed/expected vector: {issue_valid, issue_is_store, lq_pop, sq_pop, fence_ack}
   localparam logic [4:0] E_IDLE  = 5'b00000;
   localparam logic [4:0] E_LOAD  = 5'b10100;
   localparam logic [4:0] E_STORE = 5'b11010;
   localparam logic [4:0] E_ACK   = 5'b00001;
   localparam logic [4:0] E_LSTL  = 5'b10000;
   localparam logic [4:0] E_SSTL  = 5'b11000;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [4:0] exp_q[$];
   logic [4:0] exp_v;
   logic [4:0] obs_v;

   sq_issue_scheduler_if bus ();

   sq_issue_scheduler #(.STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] get_obs();
      return {bus.issue_valid, bus.issue_is_store, bus.lq_pop, bus.sq_pop, bus.fence_ack};
   endfunction

   task automatic drive(input logic lqv, input logic conf, input logic sqv,
                        input logic sqe, input logic rdy, input logic fen);
      bus.lq_valid          = lqv;
      bus.lq_store_conflict = conf;
      bus.sq_valid          = sqv;
      bus.sq_empty          = sqe;
      bus.mem_ready         = rdy;
      bus.fence_req         = fen;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 1, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      drive(1, 0, 1, 0, 1, 0);
      exp_q.push_back(E_IDLE);
      @(negedge clk);
      exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL reset_hold obs=%b exp=%b", obs_v, exp_v); end
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.push_back(E_LOAD);
      @(negedge clk);
      exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL first_load obs=%b exp=%b", obs_v, exp_v); end
      @(posedge clk); #1;
   endtask

   task automatic test_starve();
      do_reset();
      drive(1, 0, 1, 0, 1, 0);
`ifdef SQ_SCHED_STARVE_EN
      for (int i = 0; i < 15; i++) begin
         exp_q.push_back((i % 5 == 4) ? E_STORE : E_LOAD);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL starve_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
`else
      for (int i = 0; i < 100; i++) begin
         exp_q.push_back(E_LOAD);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL load_prio_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
`endif
   endtask

   task automatic test_fence_drain();
      logic [4:0] seq [6];
      seq = '{E_LOAD, E_STORE, E_STORE, E_IDLE, E_ACK, E_LOAD};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       drive(1, 0, 1, 0, 1, 1);
            1, 2:    drive(1, 0, 1, 0, 1, 0);
            default: drive(1, 0, 0, 1, 1, 0);
         endcase
         exp_q.push_back(seq[i]);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL fence_drain_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fence_empty();
      logic [4:0] seq [5];
      seq = '{E_IDLE, E_IDLE, E_ACK, E_LOAD, E_LOAD};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         // request edge, then a stray request during ACK that must be merged away
         drive(i >= 3, 0, 0, 1, 1, (i == 0) || (i == 2));
         exp_q.push_back(seq[i]);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL fence_empty_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_ready_stall();
      logic [4:0] seq [10];
`ifdef SQ_SCHED_STARVE_EN
      seq = '{E_LOAD, E_LOAD, E_LOAD, E_SSTL, E_SSTL, E_SSTL, E_LOAD, E_STORE, E_SSTL, E_STORE};
`else
      seq = '{E_LOAD, E_LOAD, E_LOAD, E_SSTL, E_SSTL, E_SSTL, E_LOAD, E_LOAD, E_SSTL, E_STORE};
`endif
      seq[3] = E_LSTL; seq[4] = E_LSTL; seq[5] = E_LSTL;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         case (i)
            3, 4, 5: drive(1, 0, 1, 0, 0, 0);
            8:       drive(1, 1, 1, 0, 0, 0);
            9:       drive(1, 1, 1, 0, 1, 0);
            default: drive(1, 0, 1, 0, 1, 0);
         endcase
         exp_q.push_back(seq[i]);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL stall_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      drive(1, 0, 1, 0, 1, 1);
      @(posedge clk); #1;
      drive(1, 0, 1, 0, 1, 0);
      exp_q.push_back(E_STORE);
      @(negedge clk);
      exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL drain_before_rst obs=%b exp=%b", obs_v, exp_v); end
      #2 rst = 1'b1;
      exp_q.push_back(E_IDLE);
      #1;
      exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL async_rst_drop obs=%b exp=%b", obs_v, exp_v); end
      drive(1, 0, 0, 1, 1, 0);
      @(posedge clk); #1;
      exp_q.push_back(E_IDLE);
      exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rst_held_no_ack obs=%b exp=%b", obs_v, exp_v); end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(E_LOAD);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL post_rst_arb_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1, i[0], 1, 0, 1, 0);
         exp_q.push_back(i[0] ? E_STORE : E_LOAD);
         @(negedge clk);
         exp_v = exp_q.pop_front(); obs_v = get_obs(); checks++;
         if (obs_v !== exp_v) begin failures++; $display("FAIL b2b_cyc%0d obs=%b exp=%b", i, obs_v, exp_v); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      drive(0, 0, 0, 1, 0, 0);
      @(posedge clk); #1;
      test_reset();
      test_starve();
      test_fence_drain();
      test_fence_empty();
      test_mem_ready_stall();
      test_reset_mid_drain();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
